// File: rtl/controller_poller.sv
// Polls two NES-style serial gamepads once per poll period and publishes
// {p2_present, p1_present, p2[7:0], p1[7:0]} with a one-cycle valid strobe.
module controller_poller #(
  parameter int unsigned HALF_PERIOD = 648,
  parameter int unsigned POLL_PERIOD = 1350000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        pad_latch,
  output logic        pad_clk,
  input  logic        pad1_data,
  input  logic        pad2_data,
  output logic [17:0] controls,
  output logic        controls_valid,
  output logic        busy
);

  localparam int unsigned CW = $clog2(2 * HALF_PERIOD);
  localparam int unsigned TW = $clog2(POLL_PERIOD);
  localparam int unsigned BW = 4;
  localparam int unsigned SW = 9;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    WAIT0,
    CLK_HI,
    CLK_LO,
    COMMIT
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [BW-1:0] bit_idx;
  logic [BW-1:0] bit_next;
  logic [TW-1:0] timer;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [SW-1:0] shift1;
  logic [SW-1:0] shift2;
  logic          sample;
  logic          p1_present;
  logic          p2_present;
  logic [17:0]   commit_word;

  // Shift registers hold raw (active-low) samples; bit 8 is the presence bit.
  assign p1_present  = ~shift1[8];
  assign p2_present  = ~shift2[8];
  assign commit_word = {p2_present, p1_present,
                        p2_present ? ~shift2[7:0] : 8'h00,
                        p1_present ? ~shift1[7:0] : 8'h00};

  // Next-state, phase counter and sample strobe.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CW'(1);
    bit_next   = bit_idx;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (timer == '0) state_next = LATCH;
      end
      LATCH: begin
        if (cnt == CW'(2 * HALF_PERIOD - 1)) begin
          state_next = WAIT0;
          cnt_next   = '0;
        end
      end
      WAIT0: begin
        if (cnt == CW'(HALF_PERIOD - 1)) begin
          sample     = 1'b1;
          state_next = CLK_HI;
          cnt_next   = '0;
          bit_next   = BW'(1);
        end
      end
      CLK_HI: begin
        if (cnt == CW'(HALF_PERIOD - 1)) begin
          state_next = CLK_LO;
          cnt_next   = '0;
        end
      end
      CLK_LO: begin
        if (cnt == CW'(HALF_PERIOD - 1)) begin
          sample   = 1'b1;
          cnt_next = '0;
          if (bit_idx == BW'(8)) begin
            state_next = COMMIT;
          end else begin
            state_next = CLK_HI;
            bit_next   = bit_idx + BW'(1);
          end
        end
      end
      COMMIT: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, timer, synchronisers and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      timer          <= '0;
      sync1          <= '0;
      sync2          <= '0;
      shift1         <= '0;
      shift2         <= '0;
      pad_latch      <= 1'b0;
      pad_clk        <= 1'b0;
      busy           <= 1'b0;
      controls_valid <= 1'b0;
      controls       <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      timer   <= (timer == TW'(POLL_PERIOD - 1)) ? '0 : timer + TW'(1);
      sync1   <= {sync1[0], pad1_data};
      sync2   <= {sync2[0], pad2_data};
      if (sample) begin
        shift1 <= {sync1[1], shift1[SW-1:1]};
        shift2 <= {sync2[1], shift2[SW-1:1]};
      end
      pad_latch      <= (state_next == LATCH);
      pad_clk        <= (state_next == CLK_HI);
      busy           <= (state_next != IDLE);
      controls_valid <= (state == COMMIT);
      if (state == COMMIT) controls <= commit_word;
    end
  end

endmodule

// File: tb/tb_controller_poller.sv
// Bench for controller_poller: pad models plus a frame-position timing model.
module tb_controller_poller;

  localparam int HP = 4;
  localparam int PP = 200;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pad_latch;
  logic        pad_clk;
  logic        pad1_data;
  logic        pad2_data;
  logic [17:0] controls;
  logic        controls_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  btn1 = 8'h00;
  logic [7:0]  btn2 = 8'h00;
  logic        pres1 = 1'b0;
  logic        pres2 = 1'b0;
  logic [7:0]  snap1 = 8'h00;
  logic [7:0]  snap2 = 8'h00;
  int          k = -1;
  logic [17:0] frame_exp = '0;
  logic [17:0] model_ctl = '0;
  logic        rnd_en = 1'b0;

  controller_poller #(.HALF_PERIOD(HP), .POLL_PERIOD(PP)) dut (
    .clock(clock),
    .reset(reset),
    .pad_latch(pad_latch),
    .pad_clk(pad_clk),
    .pad1_data(pad1_data),
    .pad2_data(pad2_data),
    .controls(controls),
    .controls_valid(controls_valid),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Shift-register gamepads: snapshot while latched, advance on pad_clk rise.
  initial begin
    int  idx;
    logic prev_clk;
    idx = 0;
    prev_clk = 1'b0;
    pad1_data = 1'b1;
    pad2_data = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (pad_latch) begin
        snap1 = btn1;
        snap2 = btn2;
        idx = 0;
      end else if (pad_clk && !prev_clk && idx < 8) begin
        idx++;
      end
      prev_clk = pad_clk;
      pad1_data = !pres1 ? 1'b1 : (idx < 8 ? ~snap1[idx] : 1'b0);
      pad2_data = !pres2 ? 1'b1 : (idx < 8 ? ~snap2[idx] : 1'b0);
    end
  end

  // Frame position since reset release, and the word the next commit must carry.
  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        k = -1;
        model_ctl = '0;
      end else begin
        k++;
        if (k % PP == 2 * HP) frame_exp = {pres2, pres1, pres2 ? snap2 : 8'h00, pres1 ? snap1 : 8'h00};
        if (k % PP == 19 * HP + 1) model_ctl = frame_exp;
      end
    end
  end

  // Every-cycle comparison against the frame-position model.
  initial begin
    int p;
    logic e_latch, e_clk, e_busy, e_valid;
    forever begin
      @(negedge clock);
      if (k < 0) begin
        e_latch = 1'b0; e_clk = 1'b0; e_busy = 1'b0; e_valid = 1'b0;
      end else begin
        p = k % PP;
        e_latch = (p < 2 * HP);
        e_clk   = (p >= 3 * HP) && (p < 19 * HP) && (((p - 3 * HP) / HP) % 2 == 0);
        e_busy  = (p < 19 * HP + 1);
        e_valid = (p == 19 * HP + 1);
      end
      check("pad_latch", 18'(pad_latch), 18'(e_latch));
      check("pad_clk", 18'(pad_clk), 18'(e_clk));
      check("busy", 18'(busy), 18'(e_busy));
      check("controls_valid", 18'(controls_valid), 18'(e_valid));
      check("controls", controls, model_ctl);
      check("latch_clk_exclusive", 18'(pad_latch & pad_clk), 18'd0);
    end
  end

  // Random live button activity, including mid-frame changes.
  initial begin
    forever begin
      @(negedge clock);
      if (rnd_en) begin
        if ($urandom_range(0, 5) == 0) btn1 = 8'($urandom);
        if ($urandom_range(0, 5) == 0) btn2 = 8'($urandom);
      end
    end
  end

  task automatic wait_p(input int target);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(k >= 0 && k % PP == target) && n < 1000);
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL wait_p timeout target %0d got %0d required %0d", target, k, target);
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("reset_controls", controls, 18'h00000);
    check("reset_outputs", {14'd0, pad_latch, pad_clk, busy, controls_valid}, 18'd0);

    // A+Start on pad 1, pad 2 absent.
    btn1 = 8'h09; pres1 = 1'b1; pres2 = 1'b0;
    #2 reset = 1'b0;
    wait_p(7);
    check("t1_latch_last", 18'(pad_latch), 18'd1);
    wait_p(8);
    check("t1_latch_off", 18'(pad_latch), 18'd0);
    wait_p(77);
    check("t2_valid", 18'(controls_valid), 18'd1);
    check("t2_controls", controls, 18'h10009);

    // Everything pressed, both present.
    wait_p(100);
    btn1 = 8'hFF; btn2 = 8'hFF; pres2 = 1'b1;
    wait_p(77);
    check("t3_controls", controls, 18'h3FFFF);

    // Reset while pad_clk is high for bit 4.
    wait_p(37);
    check("t4_clk_high", 18'(pad_clk), 18'd1);
    #2 reset = 1'b1;
    #1;
    check("t4_reset_outputs", {14'd0, pad_latch, pad_clk, busy, controls_valid}, 18'd0);
    check("t4_reset_controls", controls, 18'h00000);
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    wait_p(77);
    check("t4_clean_frame", controls, 18'h3FFFF);

    // Random activity across several frames.
    rnd_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      wait_p(100);
      pres1 = 1'($urandom_range(0, 1));
      pres2 = 1'($urandom_range(0, 1));
    end
    wait_p(100);
    rnd_en = 1'b0;

    // Pad 2 held then unplugged.
    btn1 = 8'h00; btn2 = 8'hA5; pres1 = 1'b1; pres2 = 1'b1;
    wait_p(78);
    check("t6_p2_held", controls, 18'h3A500);
    wait_p(100);
    pres2 = 1'b0;
    wait_p(78);
    check("t6_p2_present", 18'(controls[17]), 18'd0);
    check("t6_p2_buttons", 18'(controls[15:8]), 18'd0);
    check("t6_word", controls, 18'h10000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
